// File: rtl/dcache_writeline_burst_pkg.sv
// Shared types and constants for the data-cache writeline burst engine.
package dcache_writeline_burst_pkg;

    localparam int         WRITELINE_BEATS = 4;
    localparam int         AVM_AW_DEF      = 30;
    localparam logic [3:0] AVM_BYTEENABLE  = 4'hF;
    localparam logic [2:0] AVM_BURSTCOUNT  = 3'd4;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_BURST = 1'b1
    } state_t;

    // One pending writeline: 32-bit line address plus 128-bit line (160 bits).
    typedef struct packed {
        logic [31:0]  address;
        logic [127:0] line;
    } wl_entry_t;

    // Dword address of the first beat; the line offset bits [3:0] are dropped.
    function automatic logic [29:0] burst_word_addr(input logic [31:0] addr);
        return 30'((addr & 32'hFFFF_FFF0) >> 2);
    endfunction

endpackage

// File: rtl/dcache_writeline_burst_if.sv
// Writeline request and Avalon-MM write bus bundle; master = requester/memory side, slave = burst engine.
interface dcache_writeline_burst_if #(
    parameter int AVM_AW = 30
);
    logic              writeline_do;
    logic              writeline_done;
    logic [31:0]       writeline_address;
    logic [127:0]      writeline_line;
    logic              writeline_busy;
    logic [AVM_AW-1:0] avm_address;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [2:0]        avm_burstcount;
    logic              avm_write;
    logic              avm_waitrequest;

    modport master (
        output writeline_do, writeline_address, writeline_line, avm_waitrequest,
        input  writeline_done, writeline_busy, avm_address, avm_writedata,
               avm_byteenable, avm_burstcount, avm_write
    );

    modport slave (
        input  writeline_do, writeline_address, writeline_line, avm_waitrequest,
        output writeline_done, writeline_busy, avm_address, avm_writedata,
               avm_byteenable, avm_burstcount, avm_write
    );
endinterface

// File: rtl/dcache_writeline_hold.sv
// Single-entry 160-bit holding register for posted writelines.
// Only compiled when DCACHE_WRITELINE_POSTED_EN is defined.
`ifdef DCACHE_WRITELINE_POSTED_EN
module dcache_writeline_hold
    import dcache_writeline_burst_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  wl_entry_t wr_entry,
    input  logic      rd_en,
    output logic      entry_valid,
    output wl_entry_t entry
);

    logic      valid_r;
    wl_entry_t entry_r;

    // Capture into the empty slot, or release it once the engine pulls it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            entry_r <= '0;
        end else if (wr_en) begin
            valid_r <= 1'b1;
            entry_r <= wr_entry;
        end else if (rd_en) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign entry_valid = valid_r;
    assign entry       = entry_r;

endmodule
`endif

// File: rtl/dcache_writeline_burst.sv
// Accepts a 128-bit dirty line and writes it to memory as a 4-beat Avalon-MM burst.
// DCACHE_WRITELINE_POSTED_EN adds a holding register so done is returned when the line is captured.
module dcache_writeline_burst
    import dcache_writeline_burst_pkg::*;
#(
    parameter int AVM_AW = AVM_AW_DEF,
    parameter int BEATS  = WRITELINE_BEATS
) (
    input  logic clk,
    input  logic rst_n,
    dcache_writeline_burst_if.slave bus
);

    if (BEATS != WRITELINE_BEATS) begin : g_beats_cfg_error
        $error("dcache_writeline_burst: BEATS must be 4 (128-bit line / 32-bit beat)");
    end

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        beat_r;
    logic [1:0]        beat_s;
    logic [AVM_AW-1:0] addr_r;
    logic [127:0]      line_r;
    logic              src_valid_s;
    logic              load_s;
    logic              accept_s;
    logic              last_s;
    logic              done_s;
    logic              hold_valid_s;
    wl_entry_t         src_entry_s;
    logic [29:0]       addr_word_s;

`ifdef DCACHE_WRITELINE_POSTED_EN
    wl_entry_t req_entry_s;
    logic      capture_s;

    assign req_entry_s = '{address: bus.writeline_address, line: bus.writeline_line};
    assign capture_s   = bus.writeline_do & ~hold_valid_s;

    dcache_writeline_hold u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (capture_s),
        .wr_entry    (req_entry_s),
        .rd_en       (load_s),
        .entry_valid (hold_valid_s),
        .entry       (src_entry_s)
    );

    assign src_valid_s = hold_valid_s;
    assign done_s      = capture_s;
`else
    assign src_entry_s  = '{address: bus.writeline_address, line: bus.writeline_line};
    assign src_valid_s  = bus.writeline_do;
    assign hold_valid_s = 1'b0;
    assign done_s       = last_s;
`endif

    assign addr_word_s = burst_word_addr(src_entry_s.address);

    // Next state and beat counter; requests are only sampled in IDLE.
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        load_s   = 1'b0;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            STATE_IDLE: begin
                if (src_valid_s) begin
                    load_s  = 1'b1;
                    beat_s  = 2'd0;
                    state_s = STATE_BURST;
                end else begin
                    state_s = STATE_IDLE;
                end
            end
            STATE_BURST: begin
                accept_s = ~bus.avm_waitrequest;
                if (accept_s) begin
                    beat_s = beat_r + 2'd1;
                    if (beat_r == 2'd3) begin
                        last_s  = 1'b1;
                        state_s = STATE_IDLE;
                    end else begin
                        state_s = STATE_BURST;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s = STATE_IDLE;
                beat_s  = 2'd0;
            end
        endcase
    end

    // State and beat registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= STATE_IDLE;
            beat_r  <= 2'd0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
        end
    end

    // Line and address are frozen for the whole burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            line_r <= '0;
        end else if (load_s) begin
            addr_r <= addr_word_s[AVM_AW-1:0];
            line_r <= src_entry_s.line;
        end else begin
            addr_r <= addr_r;
            line_r <= line_r;
        end
    end

    assign bus.avm_write      = (state_r == STATE_BURST);
    assign bus.avm_address    = addr_r;
    assign bus.avm_writedata  = line_r[{beat_r, 5'b00000} +: 32];
    assign bus.avm_byteenable = AVM_BYTEENABLE;
    assign bus.avm_burstcount = AVM_BURSTCOUNT;
    assign bus.writeline_done = done_s;
    assign bus.writeline_busy = (state_r != STATE_IDLE) | hold_valid_s;

endmodule
